complex_frame_collector: RTL and testbench

COMPLEX_FRAME_COLLECTOR -- requirements
Module: complex_frame_collector

---
 rtl/complex_frame_collector.sv | 162 ++++++++++++++++
 tb/tb_complex_frame_collector.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_frame_collector.sv
// Ping-pong frame collector between a complex multiplier and a ready/valid consumer.
// Define COLLECTOR_DROP_CNT_EN to build the saturating 16-bit dropped-frame counter.
package complex_pkg;
   typedef struct packed {
      logic [31:0] r;
      logic [31:0] i;
   } complex_t;
endpackage

module complex_frame_collector
   import complex_pkg::*;
#(
   parameter int unsigned FRAME_LEN = 8,
   parameter int unsigned LOG_LEN   = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  complex_t    in,
   input  logic        next,
   output complex_t    out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        overflow,
   output logic [15:0] drop_count
);

   typedef enum logic [0:0] {WIdle, WFill} w_state_e;

   localparam logic [LOG_LEN-1:0] LastIdx = LOG_LEN'(FRAME_LEN - 1);

   w_state_e           w_state_q, w_state_d;
   logic [LOG_LEN-1:0] wr_idx_q, wr_idx_d;
   logic [LOG_LEN-1:0] rd_idx_q, rd_idx_d;
   logic               wr_bank_q, wr_bank_d;
   logic               rd_bank_q, rd_bank_d;
   logic [1:0]         full_q, full_d;
   logic               overflow_q, overflow_d;

   logic               xfer, rd_release;
   logic               wr_en, wr_last, complete, drop;
   logic               tgt, tgt_busy;

   complex_t           mem [2][FRAME_LEN];

   always_comb begin
      out       = mem[rd_bank_q][rd_idx_q];
      out_valid = full_q[rd_bank_q];
      out_last  = out_valid && (rd_idx_q == LastIdx);
   end

   always_comb begin
      rd_idx_d   = rd_idx_q;
      rd_bank_d  = rd_bank_q;
      rd_release = 1'b0;
      xfer       = out_valid && out_ready;
      if (xfer) begin
         if (rd_idx_q == LastIdx) begin
            rd_release = 1'b1;
            rd_idx_d   = '0;
            rd_bank_d  = ~rd_bank_q;
         end else begin
            rd_idx_d = rd_idx_q + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      wr_idx_d  = wr_idx_q;
      wr_bank_d = wr_bank_q;
      wr_en     = 1'b0;
      drop      = 1'b0;
      wr_last   = (wr_idx_q == LastIdx);
      complete  = (w_state_q == WFill) && wr_last;
      // A next coinciding with a frame's last sample targets the other bank; a bank being
      // released this cycle counts as free so back-to-back frames never drop.
      tgt       = complete ? ~wr_bank_q : wr_bank_q;
      tgt_busy  = full_q[tgt] && !(rd_release && (rd_bank_q == tgt));
      unique case (w_state_q)
         WIdle: begin
            if (next) begin
               if (tgt_busy) begin
                  drop = 1'b1;
               end else begin
                  w_state_d = WFill;
                  wr_idx_d  = '0;
               end
            end
         end
         WFill: begin
            if (next && !wr_last) begin
               wr_idx_d = '0;
            end else begin
               wr_en = 1'b1;
               if (wr_last) begin
                  wr_bank_d = ~wr_bank_q;
                  wr_idx_d  = '0;
                  w_state_d = WIdle;
                  if (next) begin
                     if (tgt_busy) drop = 1'b1;
                     else          w_state_d = WFill;
                  end
               end else begin
                  wr_idx_d = wr_idx_q + 1'b1;
               end
            end
         end
         default: w_state_d = WIdle;
      endcase
   end

   always_comb begin
      full_d = full_q;
      if (complete)   full_d[wr_bank_q] = 1'b1;
      if (rd_release) full_d[rd_bank_q] = 1'b0;
      overflow_d = overflow_q | drop;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         w_state_q  <= WIdle;
         wr_idx_q   <= '0;
         rd_idx_q   <= '0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         full_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         w_state_q  <= w_state_d;
         wr_idx_q   <= wr_idx_d;
         rd_idx_q   <= rd_idx_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && wr_en) mem[wr_bank_q][wr_idx_q] <= in;
   end

   assign overflow = overflow_q;

`ifdef COLLECTOR_DROP_CNT_EN
   logic [15:0] drop_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign drop_count = drop_cnt_q;
`else
   assign drop_count = '0;
`endif

endmodule

// File: tb/tb_complex_frame_collector.sv
// Scoreboard bench for complex_frame_collector: stimulus pushes expected samples, a monitor
// pops and compares on every out_valid && out_ready transfer.
module tb_complex_frame_collector;

   localparam int unsigned FL = 8;

   typedef struct packed {
      logic [63:0] d;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        next = 1'b0;
   logic        out_ready = 1'b0;
   logic [63:0] in_d = '0;
   logic [63:0] out_d;
   logic        out_valid, out_last, overflow;
   logic [15:0] drop_count;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] fp_tab [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

   always #5 clk = ~clk;

   complex_frame_collector #(
      .FRAME_LEN (FL),
      .LOG_LEN   (3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in         (in_d),
      .next       (next),
      .out        (out_d),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   // tag 0 is the fp32 1.0..8.0 frame; other tags give distinct bit patterns
   function automatic logic [63:0] samp(input int tag, input int idx);
      logic [31:0] r;
      if (tag == 0) r = fp_tab[idx];
      else          r = {tag[15:0], 8'h5A, idx[7:0]};
      return {r, r ^ 32'hA5A5_0F0F};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int tag, input int idx);
      exp_t e;
      e.d    = samp(tag, idx);
      e.last = (idx == FL - 1);
      sb.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   // nf frames back to back: each later next coincides with the previous frame's last sample
   task automatic drive_frames(input int nf, input int tag0, input bit push);
      next = 1'b1;
      in_d = 64'hFFFF_0000_FFFF_0000;
      tick();
      for (int f = 0; f < nf; f++) begin
         for (int s = 0; s < FL; s++) begin
            in_d = samp(tag0 + f, s);
            next = (s == FL - 1) && (f < nf - 1);
            if (push) push_exp(tag0 + f, s);
            tick();
         end
      end
      next = 1'b0;
      in_d = 64'hDEAD_BEEF_DEAD_BEEF;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
      chk(name, 64'(sb.size()), 64'd0);
      tick();
      tick();
      chk({name, "_idle"}, 64'(out_valid), 64'd0);
   endtask

   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         exp_t e;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output: got %h with nothing expected", out_d);
         end else begin
            e = sb.pop_front();
            if (out_d !== e.d || out_last !== e.last) begin
               bad++;
               $display("FAIL sample: got %h last=%b expected %h last=%b",
                        out_d, out_last, e.d, e.last);
            end
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] exp_drop;

      // reset state
      do_reset();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_last", 64'(out_last), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_drop", 64'(drop_count), 64'd0);

      // single fp32 frame, latency FRAME_LEN+1
      out_ready = 1'b1;
      next = 1'b1;
      tick();
      next = 1'b0;
      for (int s = 0; s < FL; s++) begin
         in_d = samp(0, s);
         push_exp(0, s);
         chk("lat_not_yet", 64'(out_valid), 64'd0);
         tick();
      end
      in_d = '0;
      chk("lat_valid", 64'(out_valid), 64'd1);
      chk("first_sample", out_d, samp(0, 0));
      wait_drain("single_drain");

      // backpressure: two frames fill both banks, third is dropped
      out_ready = 1'b0;
      drive_frames(2, 16'h100, 1'b1);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_hold", out_d, samp(16'h100, 0));
      chk("bp_no_ovf", 64'(overflow), 64'd0);
      drive_frames(1, 16'h300, 1'b0);
      chk("bp_ovf", 64'(overflow), 64'd1);
`ifdef COLLECTOR_DROP_CNT_EN
      exp_drop = 16'd1;
`else
      exp_drop = 16'd0;
`endif
      chk("bp_drop", 64'(drop_count), 64'(exp_drop));
      out_ready = 1'b1;
      wait_drain("bp_drain");

      // back-to-back throughput with out_ready held high
      drive_frames(4, 16'h400, 1'b1);
      wait_drain("tput_drain");
      chk("tput_drop", 64'(drop_count), 64'(exp_drop));
      chk("ovf_sticky", 64'(overflow), 64'd1);

      // restart: partial frame abandoned, not a drop
      do_reset();
      chk("rs_drop0", 64'(drop_count), 64'd0);
      chk("rs_ovf0", 64'(overflow), 64'd0);
      next = 1'b1;
      tick();
      next = 1'b0;
      for (int s = 0; s < 3; s++) begin
         in_d = samp(16'h7A, s);
         tick();
      end
      drive_frames(1, 16'hB0, 1'b1);
      wait_drain("rs_drain");
      chk("rs_drop", 64'(drop_count), 64'd0);
      chk("rs_ovf", 64'(overflow), 64'd0);

      // stall hold: out_ready 1,0,0,1 mid-frame
      out_ready = 1'b0;
      drive_frames(1, 16'h40, 1'b1);
      out_ready = 1'b1;
      tick();
      tick();
      tick();
      out_ready = 1'b0;
      chk("stall_a", out_d, samp(16'h40, 3));
      tick();
      chk("stall_b", out_d, samp(16'h40, 3));
      chk("stall_last", 64'(out_last), 64'd0);
      tick();
      chk("stall_c", out_d, samp(16'h40, 3));
      out_ready = 1'b1;
      wait_drain("stall_drain");

      // mid-frame reset while the other bank holds a full frame
      out_ready = 1'b0;
      drive_frames(1, 16'h50, 1'b0);
      chk("mr_full", 64'(out_valid), 64'd1);
      next = 1'b1;
      tick();
      next = 1'b0;
      for (int s = 0; s < 4; s++) begin
         in_d = samp(16'h51, s);
         tick();
      end
      in_d = samp(16'h51, 4);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("mr_valid", 64'(out_valid), 64'd0);
      chk("mr_ovf", 64'(overflow), 64'd0);
      chk("mr_drop", 64'(drop_count), 64'd0);
      out_ready = 1'b1;
      for (int s = 5; s < FL; s++) begin
         in_d = samp(16'h51, s);
         tick();
      end
      chk("mr_ignored", 64'(out_valid), 64'd0);
      drive_frames(1, 16'h60, 1'b1);
      wait_drain("mr_drain");

      // drop counter saturation
      do_reset();
      out_ready = 1'b0;
      drive_frames(2, 16'h70, 1'b0);
      next = 1'b1;
`ifdef COLLECTOR_DROP_CNT_EN
      for (int i = 0; i < 3; i++) tick();
      chk("sat_mid", 64'(drop_count), 64'd3);
      for (int i = 0; i < 65540; i++) tick();
      next = 1'b0;
      chk("sat_hold", 64'(drop_count), 64'hFFFF);
`else
      for (int i = 0; i < 40; i++) tick();
      next = 1'b0;
      chk("sat_off", 64'(drop_count), 64'd0);
`endif
      chk("sat_ovf", 64'(overflow), 64'd1);
      do_reset();
      chk("end_valid", 64'(out_valid), 64'd0);
      chk("end_queue", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
